// File: rtl/tcdm_bank_adapter.sv
// Bridges one multiplexed valid/ready TCDM port onto a fixed-latency SRAM bank.
// Read metadata rides a latency-matched pipeline and responses queue in a credit-protected FIFO.
module tcdm_bank_adapter #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 10,
    parameter int unsigned IniAddrWidth = 4,
    parameter int unsigned Latency      = 1,
    parameter int unsigned RspFifoDepth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_wen_i,
    input  logic [AddrWidth-1:0]      req_addr_i,
    input  logic [DataWidth-1:0]      req_wdata_i,
    input  logic [DataWidth/8-1:0]    req_be_i,
    input  logic [IniAddrWidth-1:0]   req_ini_addr_i,
    input  logic                      req_wide_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DataWidth-1:0]      rsp_rdata_o,
    output logic [IniAddrWidth-1:0]   rsp_ini_addr_o,
    output logic                      rsp_wide_o,

    output logic                      bank_req_o,
    output logic                      bank_we_o,
    output logic [AddrWidth-1:0]      bank_addr_o,
    output logic [DataWidth-1:0]      bank_wdata_o,
    output logic [DataWidth/8-1:0]    bank_be_o,
    input  logic [DataWidth-1:0]      bank_rdata_i
);

    localparam int unsigned CntWidth  = $clog2(RspFifoDepth + 1);
    localparam int unsigned SumWidth  = CntWidth + 1;
    localparam int unsigned PtrWidth  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    // Storage is rounded up to a power of two so pointer width always matches the index range.
    localparam int unsigned FifoSlots = 1 << PtrWidth;

    logic                    accept;
    logic                    rd_accept;
    logic                    pipe_exit;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [SumWidth-1:0]     credit_used;

    logic [Latency-1:0]      pipe_valid_q, pipe_valid_d;
    logic [Latency-1:0]      pipe_wide_q, pipe_wide_d;
    logic [IniAddrWidth-1:0] pipe_ini_q [Latency];
    logic [IniAddrWidth-1:0] pipe_ini_d [Latency];

    logic [DataWidth-1:0]    fifo_data_q [FifoSlots];
    logic [IniAddrWidth-1:0] fifo_ini_q  [FifoSlots];
    logic [FifoSlots-1:0]    fifo_wide_q;

    logic [PtrWidth-1:0]     wptr_q, wptr_d;
    logic [PtrWidth-1:0]     rptr_q, rptr_d;
    logic [CntWidth-1:0]     inflight_q, inflight_d;
    logic [CntWidth-1:0]     count_q, count_d;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(RspFifoDepth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Credits come only from registered state so ready never depends on valid or rsp_ready.
    assign credit_used = SumWidth'(inflight_q) + SumWidth'(count_q);
    assign req_ready_o = !rst_i && (credit_used < SumWidth'(RspFifoDepth));

    assign accept    = req_valid_i && req_ready_o;
    assign rd_accept = accept && !req_wen_i;

    assign bank_req_o   = accept;
    assign bank_we_o    = req_wen_i;
    assign bank_addr_o  = req_addr_i;
    assign bank_wdata_o = req_wdata_i;
    assign bank_be_o    = req_be_i;

    assign pipe_exit = pipe_valid_q[Latency-1];
    assign fifo_push = pipe_exit;

    assign rsp_valid_o    = !rst_i && (count_q != '0);
    assign fifo_pop       = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o    = fifo_data_q[rptr_q];
    assign rsp_ini_addr_o = fifo_ini_q[rptr_q];
    assign rsp_wide_o     = fifo_wide_q[rptr_q];

    always_comb begin
        pipe_valid_d    = '0;
        pipe_wide_d     = '0;
        pipe_ini_d      = '{default: '0};
        pipe_valid_d[0] = rd_accept;
        pipe_wide_d[0]  = req_wide_i;
        pipe_ini_d[0]   = req_ini_addr_i;
        for (int i = 1; i < Latency; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_wide_d[i]  = pipe_wide_q[i-1];
            pipe_ini_d[i]   = pipe_ini_q[i-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({rd_accept, pipe_exit})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign wptr_d = fifo_push ? ptr_inc(wptr_q) : wptr_q;
    assign rptr_d = fifo_pop  ? ptr_inc(rptr_q) : rptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
        end
        pipe_wide_q <= pipe_wide_d;
        pipe_ini_q  <= pipe_ini_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Payload needs no reset: entries are only visible once count_q covers them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fifo_push) begin
            fifo_data_q[wptr_q] <= bank_rdata_i;
            fifo_ini_q[wptr_q]  <= pipe_ini_q[Latency-1];
            fifo_wide_q[wptr_q] <= pipe_wide_q[Latency-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && fifo_push) begin
            assert (count_q < CntWidth'(RspFifoDepth));
        end
    end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Bench for tcdm_bank_adapter: two instances (Latency=1/Depth=2 and Latency=2/Depth=1) with SRAM
// models, a per-cycle credit model and a response scoreboard queue.
module tb_tcdm_bank_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        va, wen_a, wide_a, rspr_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [3:0]  be_a, ini_a;
    logic        rdy_a, rspv_a, rwide_a, breq_a, bwe_a;
    logic [31:0] rdata_a, bwdata_a, brdata_a;
    logic [3:0]  rini_a, bbe_a;
    logic [9:0]  baddr_a;

    logic        vb, wide_b, rspr_b;
    logic [9:0]  addr_b;
    logic [3:0]  ini_b;
    logic        rdy_b, rspv_b, rwide_b, breq_b, bwe_b;
    logic [31:0] rdata_b, bwdata_b, brdata_b;
    logic [3:0]  rini_b, bbe_b;
    logic [9:0]  baddr_b;

    tcdm_bank_adapter #(.Latency(1), .RspFifoDepth(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(va), .req_ready_o(rdy_a), .req_wen_i(wen_a), .req_addr_i(addr_a),
        .req_wdata_i(wdata_a), .req_be_i(be_a), .req_ini_addr_i(ini_a), .req_wide_i(wide_a),
        .rsp_valid_o(rspv_a), .rsp_ready_i(rspr_a), .rsp_rdata_o(rdata_a),
        .rsp_ini_addr_o(rini_a), .rsp_wide_o(rwide_a),
        .bank_req_o(breq_a), .bank_we_o(bwe_a), .bank_addr_o(baddr_a),
        .bank_wdata_o(bwdata_a), .bank_be_o(bbe_a), .bank_rdata_i(brdata_a)
    );

    tcdm_bank_adapter #(.Latency(2), .RspFifoDepth(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vb), .req_ready_o(rdy_b), .req_wen_i(1'b0), .req_addr_i(addr_b),
        .req_wdata_i(32'h0), .req_be_i(4'h0), .req_ini_addr_i(ini_b), .req_wide_i(wide_b),
        .rsp_valid_o(rspv_b), .rsp_ready_i(rspr_b), .rsp_rdata_o(rdata_b),
        .rsp_ini_addr_o(rini_b), .rsp_wide_o(rwide_b),
        .bank_req_o(breq_b), .bank_we_o(bwe_b), .bank_addr_o(baddr_b),
        .bank_wdata_o(bwdata_b), .bank_be_o(bbe_b), .bank_rdata_i(brdata_b)
    );

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [31:0] b_stage;

    always @(posedge clk) begin
        if (breq_a) begin
            if (bwe_a) begin
                for (int k = 0; k < 4; k++)
                    if (bbe_a[k]) mem0[baddr_a][8*k +: 8] = bwdata_a[8*k +: 8];
            end else begin
                brdata_a <= mem0[baddr_a];
            end
        end
        b_stage  <= mem1[baddr_b];
        brdata_b <= b_stage;
    end

    int checks = 0;
    int failures = 0;
    int m_infl [2];
    int m_cnt  [2];
    int pops   [2];
    logic [3:0]  m_pipe [2];
    logic [36:0] q0 [$];
    logic [36:0] q1 [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle model of one adapter, evaluated at the negedge for the coming rising edge.
    task automatic model_step(input int id, input int lat, input int dep, input logic r,
                              input logic valid, input logic wen, input logic [9:0] addr,
                              input logic [3:0] ini, input logic wide, input logic rsp_ready,
                              input logic ready_o, input logic bank_req, input logic rsp_valid,
                              input logic [31:0] rdata, input logic [3:0] rini, input logic rwide);
        logic exp_ready, acc, rd_acc, ex, pop;
        logic [36:0] head;
        if (r) begin
            check("rst_ready", ready_o, 0);
            check("rst_bank_req", bank_req, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            m_infl[id] = 0;
            m_cnt[id]  = 0;
            m_pipe[id] = '0;
            if (id == 0) q0.delete(); else q1.delete();
            return;
        end
        exp_ready = (m_infl[id] + m_cnt[id]) < dep;
        acc       = valid && exp_ready;
        rd_acc    = acc && !wen;
        check("req_ready", ready_o, exp_ready);
        check("bank_req", bank_req, acc);
        check("rsp_valid", rsp_valid, m_cnt[id] != 0);
        if (m_cnt[id] != 0) begin
            head = (id == 0) ? q0[0] : q1[0];
            check("rsp_head", {rdata, rini, rwide}, head);
        end
        pop = (m_cnt[id] != 0) && rsp_ready;
        if (rd_acc) begin
            if (id == 0) q0.push_back({mem0[addr], ini, wide});
            else         q1.push_back({mem1[addr], ini, wide});
        end
        ex = m_pipe[id][lat-1];
        m_pipe[id] = {m_pipe[id][2:0], rd_acc};
        m_infl[id] = m_infl[id] + (rd_acc ? 1 : 0) - (ex ? 1 : 0);
        m_cnt[id]  = m_cnt[id] + (ex ? 1 : 0) - (pop ? 1 : 0);
        if (pop) begin
            pops[id]++;
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 1, 2, rst, va, wen_a, addr_a, ini_a, wide_a, rspr_a,
                   rdy_a, breq_a, rspv_a, rdata_a, rini_a, rwide_a);
        model_step(1, 2, 1, rst, vb, 1'b0, addr_b, ini_b, wide_b, rspr_b,
                   rdy_b, breq_b, rspv_b, rdata_b, rini_b, rwide_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, p0, acc;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 32'h5A000000 | 32'(i);
            mem1[i] = 32'h3C000000 | 32'(i);
        end
        mem0[5] = 32'hCAFE0001;
        rst = 1'b1;
        va = 0; wen_a = 0; addr_a = '0; wdata_a = '0; be_a = '0; ini_a = '0; wide_a = 0; rspr_a = 1;
        vb = 0; addr_b = '0; ini_b = '0; wide_b = 0; rspr_b = 1;
        m_pipe[0] = '0;
        m_pipe[1] = '0;

        repeat (2) step();
        check("reset_ready", rdy_a, 0);
        check("reset_rsp_valid", rspv_a, 0);
        rst = 1'b0;
        #1;
        check("release_ready", rdy_a, 1);
        check("release_rsp_valid", rspv_a, 0);

        // Single read: response two cycles after accept.
        step();
        va = 1; wen_a = 0; addr_a = 10'h005; ini_a = 4'h3; wide_a = 1;
        #1;
        check("rd1_bank_req", breq_a, 1);
        check("rd1_bank_we", bwe_a, 0);
        check("rd1_bank_addr", baddr_a, 10'h005);
        step();
        va = 0;
        #1;
        check("rd1_early_valid", rspv_a, 0);
        step();
        check("rd1_valid", rspv_a, 1);
        check("rd1_rdata", rdata_a, 32'hCAFE0001);
        check("rd1_ini", rini_a, 4'h3);
        check("rd1_wide", rwide_a, 1);

        // Eight reads with valid held; credits allow two in every three cycles.
        step();
        n = 0; cyc = 0; p0 = pops[0];
        va = 1;
        while (n < 8 && cyc < 40) begin
            addr_a = 10'h0A0 + 10'(n); ini_a = 4'(n); wide_a = n[0];
            #1;
            if (rdy_a) n++;
            step();
            cyc++;
        end
        va = 0;
        check("b2b_accepts", n, 8);
        check("b2b_cycles", cyc, 11);
        cyc = 0;
        while ((pops[0] - p0) < 8 && cyc < 20) begin
            step();
            cyc++;
        end
        check("b2b_responses", pops[0] - p0, 8);

        // Backpressure: exactly two reads fit, ready returns the cycle after the first pop.
        step();
        rspr_a = 0; va = 1; acc = 0;
        for (int i = 0; i < 5; i++) begin
            addr_a = 10'h0C0 + 10'(i); ini_a = 4'(i + 1); wide_a = i[0];
            #1;
            if (rdy_a) acc++;
            step();
        end
        check("hold_accepts", acc, 2);
        check("hold_ready_low", rdy_a, 0);
        check("hold_head", rdata_a, 32'h5A0000C0);
        va = 0; rspr_a = 1;
        #1;
        check("hold_ready_in_pop", rdy_a, 0);
        step();
        check("hold_ready_after_pop", rdy_a, 1);
        repeat (3) step();

        // Write then read the same word.
        va = 1; wen_a = 1; addr_a = 10'h002; wdata_a = 32'h12345678; be_a = 4'hF;
        #1;
        check("wr_bank_req", breq_a, 1);
        check("wr_bank_we", bwe_a, 1);
        check("wr_bank_wdata", bwdata_a, 32'h12345678);
        check("wr_bank_be", bbe_a, 4'hF);
        step();
        wen_a = 0; ini_a = 4'h7; wide_a = 0;
        #1;
        check("rd2_bank_we", bwe_a, 0);
        step();
        va = 0;
        #1;
        check("wr_no_rsp", rspv_a, 0);
        step();
        check("rd2_valid", rspv_a, 1);
        check("rd2_rdata", rdata_a, 32'h12345678);
        check("rd2_ini", rini_a, 4'h7);
        repeat (2) step();

        // Depth 1, latency 2: one accept every four cycles under continuous valid.
        vb = 1; acc = 0;
        for (int i = 0; i < 13; i++) begin
            addr_b = 10'h040 + 10'(i); ini_b = 4'(i); wide_b = i[1];
            #1;
            if (rdy_b) acc++;
            step();
        end
        vb = 0;
        check("d1_accepts", acc, 4);
        repeat (5) step();

        // Reset with one read queued and one in flight.
        rspr_a = 0;
        va = 1; addr_a = 10'h030; ini_a = 4'h1; wide_a = 1;
        step();
        addr_a = 10'h031; ini_a = 4'h2;
        step();
        va = 0; rst = 1;
        #1;
        check("midrst_ready", rdy_a, 0);
        check("midrst_rsp_valid", rspv_a, 0);
        step();
        rst = 0;
        #1;
        check("postrst_ready", rdy_a, 1);
        check("postrst_rsp_valid", rspv_a, 0);
        rspr_a = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postrst_stale", rspv_a, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
